lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_ctrl.sv | 106 ++++++++++
 tb/tb_lock_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// lock_ctrl: digit-code lock FSM with fail lockout; optional auto-relock via LOCK_AUTORELOCK_EN
module lock_ctrl #(
    parameter int CODE_LEN = 4,
    parameter logic [CODE_LEN*4-1:0] SECRET = 16'h1234,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_CYCLES = 8,
    parameter int AUTO_RELOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       clear,
    input  logic       lock_req,
    output logic       state,
    output logic       err,
    output logic       lockout,
    output logic [2:0] digit_cnt
);
    localparam int W = CODE_LEN * 4;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TMAX = LOCKOUT_CYCLES > AUTO_RELOCK_CYCLES ? LOCKOUT_CYCLES : AUTO_RELOCK_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT} st_t;
    st_t fsm;
    logic [W-1:0] code;
    logic [FW-1:0] fails;
    logic [TW-1:0] timer;
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            state <= 1'b0;
            err <= 1'b0;
            lockout <= 1'b0;
            digit_cnt <= '0;
            code <= '0;
            fails <= '0;
            timer <= '0;
        end else begin
            err <= 1'b0;
            case (fsm)
                IDLE, ENTRY: begin
                    if (clear) begin
                        code <= '0;
                        digit_cnt <= '0;
                        fsm <= IDLE;
                    end else if (digit_valid) begin
                        code <= {code[W-5:0], digit};
                        if (digit_cnt == 3'(CODE_LEN - 1)) begin
                            digit_cnt <= '0;
                            fsm <= CHECK;
                        end else begin
                            digit_cnt <= digit_cnt + 3'd1;
                            fsm <= ENTRY;
                        end
                    end
                end
                CHECK: begin
                    code <= '0;
                    if (code == SECRET) begin
                        fsm <= UNLOCKED;
                        state <= 1'b1;
                        fails <= '0;
                    end else begin
                        err <= 1'b1;
                        fails <= (fails == FW'(MAX_FAIL)) ? fails : fails + FW'(1);
                        if (fails >= FW'(MAX_FAIL - 1)) begin
                            fsm <= LOCKOUT;
                            lockout <= 1'b1;
                            timer <= '0;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                UNLOCKED: begin
                    if (lock_req) begin
                        fsm <= IDLE;
                        state <= 1'b0;
                        timer <= '0;
                    end
`ifdef LOCK_AUTORELOCK_EN
                    else if (timer == TW'(AUTO_RELOCK_CYCLES - 1)) begin
                        fsm <= IDLE;
                        state <= 1'b0;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
`endif
                end
                LOCKOUT: begin
                    if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
                        fsm <= IDLE;
                        lockout <= 1'b0;
                        fails <= '0;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: directed self-checking bench for lock_ctrl
module tb_lock_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] digit = '0;
    logic digit_valid = 1'b0;
    logic clear = 1'b0;
    logic lock_req = 1'b0;
    logic state, err, lockout;
    logic [2:0] digit_cnt;
    int checks = 0;
    int errors = 0;

    lock_ctrl dut (
        .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid),
        .clear(clear), .lock_req(lock_req), .state(state), .err(err),
        .lockout(lockout), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dig(input logic [3:0] d);
        digit = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    // four digits then the CHECK edge
    task automatic enter(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) dig(c[i*4+:4]);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_err", err, 0);
        chk("rst_lockout", lockout, 0);
        chk("rst_cnt", digit_cnt, 0);
        rst = 1'b0;

        dig(4'h1);
        dig(4'h2);
        dig(4'h3);
        chk("cnt3", digit_cnt, 3);
        dig(4'h4);
        chk("check_cycle_state", state, 0);
        chk("check_cycle_cnt", digit_cnt, 0);
        tick();
        chk("unlock", state, 1);
        chk("unlock_err", err, 0);
        dig(4'h1);
        chk("unlocked_ignore_digit", digit_cnt, 0);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        chk("relock", state, 0);

        for (int i = 3; i >= 0; i--) dig(i == 0 ? 4'h5 : 4'(4 - i));
        chk("wrong_err_pre", err, 0);
        tick();
        chk("wrong_err", err, 1);
        chk("wrong_state", state, 0);
        tick();
        chk("wrong_err_1cyc", err, 0);
        enter(16'h1234);
        chk("recover_unlock", state, 1);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;

        enter(16'h1111);
        enter(16'h2222);
        chk("two_wrong_no_lockout", lockout, 0);
        enter(16'h3333);
        chk("lockout_on", lockout, 1);
        for (int i = 1; i < 8; i++) begin
            if (i <= 4) begin
                digit = 4'(i);
                digit_valid = 1'b1;
            end
            tick();
            digit_valid = 1'b0;
            chk("lockout_hold", lockout, 1);
            chk("lockout_ignore_cnt", digit_cnt, 0);
        end
        chk("lockout_state", state, 0);
        tick();
        chk("lockout_end", lockout, 0);
        chk("lockout_end_state", state, 0);
        enter(16'h1234);
        chk("post_lockout_unlock", state, 1);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;

        dig(4'h1);
        dig(4'h2);
        digit = 4'h3;
        digit_valid = 1'b1;
        clear = 1'b1;
        tick();
        digit_valid = 1'b0;
        clear = 1'b0;
        chk("clear_wins", digit_cnt, 0);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        chk("lockreq_idle_noeffect", state, 0);
        enter(16'h1234);
        chk("clear_then_unlock", state, 1);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        chk("clear_relock", state, 0);

        dig(4'h1);
        dig(4'h2);
        chk("mid_cnt", digit_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cnt", digit_cnt, 0);
        chk("mid_rst_state", state, 0);
        enter(16'h1234);
        chk("mid_rst_buffer_clear", state, 1);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;

        enter(16'h9999);
        enter(16'h9999);
        enter(16'h9999);
        tick();
        chk("lockout_before_rst", lockout, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lo_rst_lockout", lockout, 0);
        chk("lo_rst_err", err, 0);
        chk("lo_rst_cnt", digit_cnt, 0);
        chk("lo_rst_state", state, 0);
        enter(16'h1234);
        chk("lo_rst_unlock", state, 1);

`ifdef LOCK_AUTORELOCK_EN
        for (int i = 1; i < 16; i++) tick();
        chk("auto_hold15", state, 1);
        tick();
        chk("auto_relock16", state, 0);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("persist100", state, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
